muldiv_seq: RTL

- Iterative sequencer for the RV32M multiply/divide ops: R-type, opcode 0110011, func7 = 0000001, dispatched in parallel with alu_control when that func7 is decoded.
- Latches the operands, runs a radix-2 shift-add multiply or restoring divide over XLEN cycles, then applies sign correction.
- Raises a stall to the single-cycle core until the result is ready for writeback.

---
 rtl/muldiv_seq_if.sv | 36 +++
 rtl/muldiv_seq.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq_if.sv
// rtl/muldiv_seq_if.sv - core-side request/response bundle for the iterative mul/div sequencer
//
// Purpose: groups the request and response signals exchanged between the
// single-cycle core and muldiv_seq.
// Signals:
//   start  - request; the sequencer samples it only while idle
//   func3  - RV32M op select (MUL..REMU)
//   op_a   - rs1 value (multiplicand / dividend)
//   op_b   - rs2 value (multiplier / divisor)
//   busy   - sequencer iterating or applying sign correction
//   done   - one-cycle pulse; result valid in that cycle
//   result - final value, held until the next accepted start
//   stall  - core stall request
// Modports: master = core side, slave = sequencer side.
interface muldiv_seq_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      func3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic            stall;

  modport master (
    output start, func3, op_a, op_b,
    input  busy, done, result, stall
  );

  modport slave (
    input  start, func3, op_a, op_b,
    output busy, done, result, stall
  );
endinterface

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative RV32M multiply/divide sequencer with core stall
//
// Purpose: latches operands on an accepted start, runs a radix-2 shift-add
// multiply or a restoring divide over XLEN cycles, applies sign correction in
// one FIX cycle, then pulses done for one cycle. Divide-by-zero and signed
// overflow are resolved at start and complete one cycle later.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - muldiv_seq_if slave modport (start/func3/op_a/op_b in,
//           busy/done/result/stall out)
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  muldiv_seq_if.slave bus
);

  localparam int              CW       = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST_IT  = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL_IT,
    S_DIV_IT,
    S_FIX,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [2:0]        r_func3;
  logic              r_neg_a;
  logic              r_neg_b;
  // Multiplicand for MUL ops, divisor for DIV ops.
  logic [XLEN-1:0]   r_opnd;
  // MUL: {high product, multiplier/low product}; DIV: {remainder, quotient}.
  logic [2*XLEN-1:0] r_acc;
  logic [CW-1:0]     r_count;
  logic [XLEN-1:0]   r_result;

  // Start decode
  logic              w_accept;
  logic              w_a_signed;
  logic              w_b_signed;
  logic              w_neg_a;
  logic              w_neg_b;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic              w_div_zero;
  logic              w_div_ovf;
  logic              w_special;
  logic [XLEN-1:0]   w_special_val;

  assign w_accept   = (r_state == S_IDLE) && bus.start;
  assign w_a_signed = bus.func3 inside {3'b001, 3'b010, 3'b100, 3'b110};
  assign w_b_signed = bus.func3 inside {3'b001, 3'b100, 3'b110};
  assign w_neg_a    = w_a_signed && bus.op_a[XLEN-1];
  assign w_neg_b    = w_b_signed && bus.op_b[XLEN-1];
  assign w_a_mag    = w_neg_a ? -bus.op_a : bus.op_a;
  assign w_b_mag    = w_neg_b ? -bus.op_b : bus.op_b;

  assign w_div_zero = bus.func3[2] && (bus.op_b == '0);
  // Only the signed DIV/REM encodings (func3[0]=0) can overflow.
  assign w_div_ovf  = bus.func3[2] && !bus.func3[0] &&
                      (bus.op_a == MIN_NEG) && (bus.op_b == ALL_ONES);
  assign w_special  = w_div_zero || w_div_ovf;
  // func3[1] separates REM/REMU from DIV/DIVU.
  assign w_special_val = w_div_zero ? (bus.func3[1] ? bus.op_a : ALL_ONES)
                                    : (bus.func3[1] ? '0 : MIN_NEG);

  // Multiply step: conditional add into the high half with carry, then shift right.
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_next;

  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} +
                      (r_acc[0] ? {1'b0, r_opnd} : {(XLEN+1){1'b0}});
  assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

  // Divide step: the shifted partial remainder needs XLEN+1 bits; the MSB of
  // the trial difference is the borrow that decides restore vs keep.
  logic [XLEN:0]     w_rem_sh;
  logic [XLEN:0]     w_diff;
  logic [2*XLEN-1:0] w_div_next;

  assign w_rem_sh   = r_acc[2*XLEN-1:XLEN-1];
  assign w_diff     = w_rem_sh - {1'b0, r_opnd};
  assign w_div_next = w_diff[XLEN] ? {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                   : {w_diff[XLEN-1:0],   r_acc[XLEN-2:0], 1'b1};

  // Sign correction and output select
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_fix_val;

  assign w_prod = (r_neg_a ^ r_neg_b) ? -r_acc : r_acc;
  assign w_quo  = (r_neg_a ^ r_neg_b) ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_rem  = r_neg_a ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

  always_comb begin
    w_fix_val = '0;
    case (r_func3)
      3'b000:                 w_fix_val = w_prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_fix_val = w_prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_fix_val = w_quo;
      default:                w_fix_val = w_rem;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next state and outputs
  always_comb begin
    w_next     = r_state;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (w_special)         w_next = S_DONE;
          else if (bus.func3[2]) w_next = S_DIV_IT;
          else                   w_next = S_MUL_IT;
        end
      end
      S_MUL_IT, S_DIV_IT: begin
        bus.busy = 1'b1;
        if (r_count == LAST_IT) w_next = S_FIX;
      end
      S_FIX: begin
        bus.busy = 1'b1;
        w_next   = S_DONE;
      end
      S_DONE: begin
        bus.done = 1'b1;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign bus.stall  = w_accept || bus.busy;
  assign bus.result = r_result;

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_func3  <= '0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_count  <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_func3 <= bus.func3;
            r_neg_a <= w_neg_a;
            r_neg_b <= w_neg_b;
            r_opnd  <= bus.func3[2] ? w_b_mag : w_a_mag;
            r_acc   <= {{XLEN{1'b0}}, (bus.func3[2] ? w_a_mag : w_b_mag)};
            r_count <= '0;
            if (w_special) r_result <= w_special_val;
          end
        end
        S_MUL_IT: begin
          r_acc   <= w_mul_next;
          r_count <= r_count + CW'(1);
        end
        S_DIV_IT: begin
          r_acc   <= w_div_next;
          r_count <= r_count + CW'(1);
        end
        S_FIX: begin
          r_result <= w_fix_val;
        end
        default: ;
      endcase
    end
  end

endmodule
